// File: rtl/ides1p3_wordalign.sv
// SDR input deserializer: captures D on enabled SCLK edges, assembles W-bit words MSB-first,
// supports one-bit-per-cycle word slip (ALIGNWD) and training lock. Option: IDES_META_SYNC_EN.

module ides1p3_gsr (
    output logic GSRNET
);
    // Behavioural stand-in for the device-wide reset net; idle high.
    assign GSRNET = 1'b1;
endmodule

module ides1p3_wordalign #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   TRAIN_PAT = 4'b1100,
    parameter int             LOCK_CNT  = 4,
    parameter                 GSR       = "ENABLED"
) (
    input  logic         SCLK,
    input  logic         RSTN,
    input  logic         D,
    input  logic         SP,
    input  logic         ALIGNWD,
    output logic [W-1:0] Q,
    output logic         VALID,
    output logic         LOCKED
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [3:0]     LOCK_MAX = 4'(LOCK_CNT);

    logic          rstn_int;
    logic          din;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [3:0]    mcnt;
    logic [W-1:0]  word_nxt;
    logic          word_done;

    generate
        if (GSR == "ENABLED") begin : g_gsr
            logic gsrnet;
            ides1p3_gsr GSR_INST (.GSRNET(gsrnet));
            assign rstn_int = RSTN & gsrnet;
        end else begin : g_nogsr
            assign rstn_int = RSTN;
        end
    endgenerate

    // Saturating increment of the training-match counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] m);
        logic [4:0] n;
        n = {1'b0, m} + 5'd1;
        if (n >= {1'b0, LOCK_MAX})
            return LOCK_MAX;
        return n[3:0];
    endfunction

`ifdef IDES_META_SYNC_EN
    logic d_p0, d_p1;

    // Stage p0/p1: free-running two-flop synchronizer on the pad input.
    always_ff @(posedge SCLK or negedge rstn_int) begin
        if (!rstn_int) begin
            d_p0 <= 1'b0;
            d_p1 <= 1'b0;
        end else begin
            d_p0 <= D;
            d_p1 <= d_p0;
        end
    end

    assign din = d_p1;
`else
    assign din = D;
`endif

    assign word_nxt  = {sr[W-2:0], din};
    assign word_done = SP && !ALIGNWD && (cnt == CNT_LAST);

    // Capture stage: shift, phase count, word output and lock tracking.
    always_ff @(posedge SCLK or negedge rstn_int) begin
        if (!rstn_int) begin
            sr     <= '0;
            cnt    <= '0;
            Q      <= '0;
            VALID  <= 1'b0;
            LOCKED <= 1'b0;
            mcnt   <= '0;
        end else begin
            VALID <= 1'b0;
            if (SP) begin
                sr <= word_nxt;
                // A slip cycle still shifts but freezes the phase, moving the boundary one bit later.
                if (!ALIGNWD)
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (word_done) begin
                Q     <= word_nxt;
                VALID <= 1'b1;
                if (word_nxt == TRAIN_PAT) begin
                    mcnt <= sat_inc(mcnt);
                    if (sat_inc(mcnt) == LOCK_MAX)
                        LOCKED <= 1'b1;
                end else begin
                    mcnt   <= '0;
                    LOCKED <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ides1p3_wordalign.sv
// Self-checking bench for ides1p3_wordalign against a bit-history reference model.

module tb_ides1p3_wordalign;

    localparam int         W   = 4;
    localparam logic [3:0] TP  = 4'b1100;
    localparam int         LC  = 4;
`ifdef IDES_META_SYNC_EN
    localparam int         LAT = 2;
`else
    localparam int         LAT = 0;
`endif

    logic       SCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       D = 1'b0;
    logic       SP = 1'b0;
    logic       ALIGNWD = 1'b0;
    logic [3:0] Q;
    logic       VALID;
    logic       LOCKED;

    int errors = 0;
    int checks = 0;

    always #5 SCLK = ~SCLK;

    ides1p3_wordalign #(
        .W(W), .TRAIN_PAT(TP), .LOCK_CNT(LC), .GSR("ENABLED")
    ) dut (
        .SCLK(SCLK), .RSTN(RSTN), .D(D), .SP(SP), .ALIGNWD(ALIGNWD),
        .Q(Q), .VALID(VALID), .LOCKED(LOCKED)
    );

    // Reference model: last W captured bits, count of non-slip captures, lock state.
    bit         hist[$];
    int         ncnt;
    int         m_mcnt;
    logic [3:0] m_q;
    logic       m_valid;
    logic       m_locked;
    logic       dl0, dl1;

    // Stimulus schedule in the capture domain (what the shift register sees per enabled edge).
    int cd[$];
    int csp[$];
    int cal[$];

    task model_clear;
        hist.delete();
        for (int i = 0; i < W; i++) hist.push_back(1'b0);
        ncnt = 0; m_mcnt = 0; m_q = '0; m_valid = 0; m_locked = 0;
        dl0 = 0; dl1 = 0;
    endtask

    task apply_reset;
        RSTN = 1'b0; D = 1'b0; SP = 1'b0; ALIGNWD = 1'b0;
        model_clear;
        repeat (2) @(negedge SCLK);
        RSTN = 1'b1;
    endtask

    task step(input logic d, input logic sp, input logic al);
        logic       cap;
        logic [3:0] w;
        D = d; SP = sp; ALIGNWD = al;
        @(posedge SCLK);
`ifdef IDES_META_SYNC_EN
        cap = dl1; dl1 = dl0; dl0 = d;
`else
        cap = d;
`endif
        m_valid = 1'b0;
        if (sp) begin
            hist.push_back(cap);
            void'(hist.pop_front());
            if (!al) begin
                ncnt++;
                if (ncnt % W == 0) begin
                    for (int i = 0; i < W; i++) w[W-1-i] = hist[i];
                    m_q = w;
                    m_valid = 1'b1;
                    if (w == TP) begin
                        m_mcnt = (m_mcnt + 1 > LC) ? LC : m_mcnt + 1;
                        if (m_mcnt >= LC) m_locked = 1'b1;
                    end else begin
                        m_mcnt = 0;
                        m_locked = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    // D is applied LAT cycles ahead of the enable so the captured bits match the schedule.
    task drive_cycle(input int k);
        logic d, sp, al;
        d  = (k < cd.size()) ? cd[k][0] : 1'b0;
        sp = 1'b0; al = 1'b0;
        if (k >= LAT && (k - LAT) < csp.size()) begin
            sp = csp[k-LAT][0];
            al = cal[k-LAT][0];
        end
        step(d, sp, al);
    endtask

    task sched_clear;
        cd.delete(); csp.delete(); cal.delete();
    endtask

    task sched_add(input int b, input int sp, input int al);
        cd.push_back(b); csp.push_back(sp); cal.push_back(al);
    endtask

    task sched_word(input logic [3:0] w);
        for (int i = W - 1; i >= 0; i--) sched_add(w[i], 1, 0);
    endtask

    task test_reset;
        logic [3:0] qs[$];
        apply_reset;
        checks++;
        if ({Q, VALID, LOCKED} !== 6'b0) begin
            errors++;
            $display("FAIL reset_init: Q=%b VALID=%b LOCKED=%b, required all zero", Q, VALID, LOCKED);
        end
        sched_clear;
        sched_word(4'b1011);
        sched_add(1, 1, 0); sched_add(1, 1, 0);
        for (int k = 0; k < cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL reset_pre cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
        end
        #2 RSTN = 1'b0;
        model_clear;
        #1;
        checks++;
        if ({Q, VALID, LOCKED} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: Q=%b VALID=%b LOCKED=%b, required all zero", Q, VALID, LOCKED);
        end
        @(negedge SCLK);
        RSTN = 1'b1;
        sched_clear;
        sched_word(4'b0111);
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL reset_post cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
            if (VALID === 1'b1) qs.push_back(Q);
        end
        checks++;
        if (qs.size() != 1 || qs[0] !== 4'b0111) begin
            errors++;
            $display("FAIL reset_first_word: words=%0d first=%b, required 1 word 0111",
                     qs.size(), (qs.size() > 0) ? qs[0] : 4'bx);
        end
    endtask

    task test_basic;
        int         vcyc[$];
        logic [3:0] qs[$];
        apply_reset;
        sched_clear;
        sched_word(4'b1011);
        sched_word(4'b0110);
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL basic cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
            if (VALID === 1'b1) begin vcyc.push_back(k); qs.push_back(Q); end
        end
        checks++;
        if (vcyc.size() != 2) begin
            errors++;
            $display("FAIL basic_valid_count: got %0d pulses, required 2", vcyc.size());
        end else if (qs[0] !== 4'b1011 || qs[1] !== 4'b0110 || vcyc[0] != 3 + LAT || vcyc[1] != 7 + LAT) begin
            errors++;
            $display("FAIL basic_words: got %b@%0d %b@%0d, required 1011@%0d 0110@%0d",
                     qs[0], vcyc[0], qs[1], vcyc[1], 3 + LAT, 7 + LAT);
        end
    endtask

    task test_enable;
        int         vcyc[$];
        logic [3:0] qs[$];
        apply_reset;
        sched_clear;
        sched_add(1, 1, 0); sched_add(0, 1, 0);
        for (int i = 0; i < 3; i++) sched_add($urandom_range(0, 1), 0, $urandom_range(0, 1));
        sched_add(1, 1, 0); sched_add(1, 1, 0);
        sched_word(4'b0110);
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL enable cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
            if (SP === 1'b0) begin
                checks++;
                if (VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL enable_gap cyc %0d: VALID=%b, required 0", k, VALID);
                end
            end
            if (VALID === 1'b1) begin vcyc.push_back(k); qs.push_back(Q); end
        end
        checks++;
        if (vcyc.size() != 2) begin
            errors++;
            $display("FAIL enable_valid_count: got %0d pulses, required 2", vcyc.size());
        end else if (qs[0] !== 4'b1011 || qs[1] !== 4'b0110 || vcyc[0] != 6 + LAT || vcyc[1] != 10 + LAT) begin
            errors++;
            $display("FAIL enable_words: got %b@%0d %b@%0d, required 1011@%0d 0110@%0d",
                     qs[0], vcyc[0], qs[1], vcyc[1], 6 + LAT, 10 + LAT);
        end
    endtask

    task test_slip;
        logic [3:0] pat;
        logic [3:0] qs[$];
        logic [3:0] exp_q[9];
        int         c;
        pat = 4'b0110;
        exp_q = '{4'b0110, 4'b0110, 4'b0110, 4'b1100, 4'b1100, 4'b1100, 4'b1001, 4'b1001, 4'b1001};
        apply_reset;
        sched_clear;
        for (c = 0; c < 38; c++) sched_add(pat[3 - (c % 4)], 1, (c == 12 || c == 25) ? 1 : 0);
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL slip cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
            if (VALID === 1'b1) qs.push_back(Q);
        end
        checks++;
        if (qs.size() != 9) begin
            errors++;
            $display("FAIL slip_count: got %0d words, required 9", qs.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (qs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL slip_word %0d: got %b, required %b", i, qs[i], exp_q[i]);
                end
            end
        end
    endtask

    task test_lock;
        logic [3:0] words[12];
        logic       exp_l[12];
        logic       lk[$];
        words = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1101, 4'b1100,
                  4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0000};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        apply_reset;
        sched_clear;
        for (int i = 0; i < 12; i++) sched_word(words[i]);
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL lock cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
            if (VALID === 1'b1) lk.push_back(LOCKED);
        end
        checks++;
        if (lk.size() != 12) begin
            errors++;
            $display("FAIL lock_count: got %0d words, required 12", lk.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (lk[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL lock_word %0d: LOCKED=%b, required %b", i, lk[i], exp_l[i]);
                end
            end
        end
    endtask

    task test_random;
        int mode;
        apply_reset;
        sched_clear;
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) mode = $urandom_range(0, 2);
            sched_add((mode != 0) ? TP[3 - (c % 4)] : $urandom_range(0, 1),
                      ($urandom_range(0, 9) < 8) ? 1 : 0,
                      ($urandom_range(0, 19) == 0) ? 1 : 0);
        end
        for (int k = 0; k <= cd.size() + LAT; k++) begin
            drive_cycle(k);
            checks++;
            if ({Q, VALID, LOCKED} !== {m_q, m_valid, m_locked}) begin
                errors++;
                $display("FAIL random cyc %0d: Q=%b V=%b L=%b, required Q=%b V=%b L=%b",
                         k, Q, VALID, LOCKED, m_q, m_valid, m_locked);
            end
        end
    endtask

    initial begin
        model_clear;
        test_reset;
        test_basic;
        test_enable;
        test_slip;
        test_lock;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
